// File: rtl/bin_to_bcd.sv
// Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter feeding the 7-segment decoders.
// Optional build macro: LEADING_ZERO_BLANK_EN replaces leading zero digits with 4'hF (blank) on output.
module bin_to_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_resetN,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FINISH
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [WIDTH-1:0]      r_shift;
    logic [4*DIGITS-1:0]   r_work;
    logic [CW-1:0]         r_count;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_done;

    logic [4*DIGITS-1:0]   w_adjusted;
    logic [4*DIGITS-1:0]   w_nextWork;
    logic [WIDTH-1:0]      w_nextShift;
    logic [4*DIGITS-1:0]   w_bcdOut;

    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_start) w_nextState = CONV;
            CONV:    if (r_count == LAST_ITER) w_nextState = FINISH;
            FINISH:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Each nibble is corrected independently so that the following doubling carries correctly into the next digit.
    always_comb begin
        w_adjusted = r_work;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_work[4*d +: 4] >= 4'd5) begin
                w_adjusted[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
            end
        end
        w_nextWork  = {w_adjusted[4*DIGITS-2:0], r_shift[WIDTH-1]};
        w_nextShift = {r_shift[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        w_bcdOut = r_work;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic w_leading;
            w_leading = 1'b1;
            // Digit 0 is excluded so a zero value still shows a single "0".
            for (int d = DIGITS - 1; d > 0; d--) begin
                if (w_leading && (r_work[4*d +: 4] == 4'd0)) begin
                    w_bcdOut[4*d +: 4] = 4'hF;
                end else begin
                    w_leading = 1'b0;
                end
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_shift <= '0;
            r_work  <= '0;
            r_count <= '0;
            r_bcd   <= '1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_shift <= i_bin;
                        r_work  <= '0;
                        r_count <= '0;
                    end
                end
                CONV: begin
                    r_work  <= w_nextWork;
                    r_shift <= w_nextShift;
                    r_count <= r_count + 1'b1;
                end
                FINISH: begin
                    r_bcd  <= w_bcdOut;
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed and random conversions against an arithmetic decimal model.
// Build with LEADING_ZERO_BLANK_EN defined to check the leading-zero blanking variant.
module tb_bin_to_bcd;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int LATENCY = WIDTH + 1;

    logic                 clk = 1'b0;
    logic                 resetN;
    logic                 start;
    logic [WIDTH-1:0]     bin;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  bcd;

    int total = 0;
    int bad   = 0;

    bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .i_clk    (clk),
        .i_resetN (resetN),
        .i_start  (start),
        .i_bin    (bin),
        .o_busy   (busy),
        .o_done   (done),
        .o_bcd    (bcd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Decimal digits by repeated division, then optional blanking of leading zeros.
    function automatic logic [4*DIGITS-1:0] refBcd(input int unsigned v);
        int unsigned rem;
        logic [4*DIGITS-1:0] r;
        rem = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int d = DIGITS - 1; d > 0; d--) begin
            if (r[4*d +: 4] != 4'd0) break;
            r[4*d +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    // Called at a negedge while idle; returns at the negedge just after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] v);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for DONE; optionally pulses START with BIN=9 at busy cycle injectAt.
    task automatic waitDone(input int injectAt, output int doneEdge, output int busyCycles, output bit bcdStable);
        logic [4*DIGITS-1:0] b0;
        b0 = bcd;
        doneEdge = -1;
        busyCycles = 0;
        bcdStable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (injectAt > 0 && k == injectAt) begin
                start = 1'b1;
                bin   = 16'd9;
            end else if (injectAt > 0 && k == injectAt + 1) begin
                start = 1'b0;
            end
            if (busy) busyCycles++;
            if (done) begin
                doneEdge = k - 1;
                break;
            end
            if (bcd !== b0) bcdStable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic runConversion(input logic [WIDTH-1:0] v, input int injectAt, input string tag);
        int doneEdge;
        int busyCycles;
        bit bcdStable;
        applyStimulus(v);
        waitDone(injectAt, doneEdge, busyCycles, bcdStable);
        checkOutput({tag, ".doneEdge"}, doneEdge, LATENCY);
        checkOutput({tag, ".busyCycles"}, busyCycles, LATENCY);
        checkOutput({tag, ".bcdHeld"}, {31'd0, bcdStable}, 32'd1);
        checkOutput({tag, ".bcd"}, {12'd0, bcd}, {12'd0, refBcd(v)});
        checkOutput({tag, ".busyAtDone"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic checkDoneFalls(input string tag);
        @(negedge clk);
        checkOutput({tag, ".doneWidth"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int doneCount;
        bit changed;
        logic [WIDTH-1:0] v;

        resetN = 1'b0;
        start  = 1'b0;
        bin    = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);
        checkOutput("reset.done", {31'd0, done}, 32'd0);
        checkOutput("reset.bcd", {12'd0, bcd}, 32'h000FFFFF);

        resetN = 1'b1;
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'hFFFFF) changed = 1'b1;
        end
        checkOutput("idle.noChange", {31'd0, changed}, 32'd0);

        runConversion(16'd12345, 0, "c12345");
        checkDoneFalls("c12345");
        runConversion(16'hFFFF, 0, "cFFFF");
        checkDoneFalls("cFFFF");
        runConversion(16'd0, 0, "c0");
        checkDoneFalls("c0");
        runConversion(16'd42, 0, "c42");
        checkDoneFalls("c42");

        // START during BUSY must be ignored; START in the DONE cycle starts the next conversion.
        runConversion(16'd12345, 5, "ignored");
        runConversion(16'd9, 0, "backToBack");
        doneCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("backToBack.extraDone", doneCount, 0);
        checkOutput("backToBack.idle", {31'd0, busy}, 32'd0);

        applyStimulus(16'd500);
        for (int k = 1; k < 8; k++) @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        checkOutput("midReset.busy", {31'd0, busy}, 32'd0);
        checkOutput("midReset.done", {31'd0, done}, 32'd0);
        checkOutput("midReset.bcd", {12'd0, bcd}, 32'h000FFFFF);
        doneCount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("midReset.noDone", doneCount, 0);
        checkOutput("midReset.bcdKept", {12'd0, bcd}, 32'h000FFFFF);
        runConversion(16'd500, 0, "after500");
        checkDoneFalls("after500");

        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) v = WIDTH'($urandom_range(0, 999));
            else v = WIDTH'($urandom_range(0, 65535));
            runConversion(v, 0, $sformatf("rand%0d", i));
        end
        checkDoneFalls("randLast");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It is the stage directly upstream of the 7-segment decoders. It takes an unsigned binary value from the CPU output register and produces one 4-bit digit per display. Each digit feeds one decoder's `DIN`. A digit code of 4'hF drives that decoder to a blank display.

## Interface
- `WIDTH`, 16: width of the binary input.
- `DIGITS`, 5: number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH.
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RESET_N` in 1: reset; synchronous, active-low.
- `START` in 1: conversion request. Sampled only while idle.
- `BIN` in WIDTH: unsigned value to convert. Sampled on the edge that accepts `START`.
- `BUSY` out 1: high while a conversion is in progress.
- `DONE` out 1: one-cycle pulse when `BCD` has been updated.
- `BCD` out 4*DIGITS: converted digits. Digit 0 (least significant) is in `[3:0]`; digit DIGITS-1 is in the top nibble. Registered.

## Operation
- States: `IDLE`, `CONV`, `FINISH`.
- `IDLE`:
  - If `START`=1 at an edge: load `BIN` into the shift register, clear the 4*DIGITS working register, clear the iteration counter, go to `CONV`.
  - If `START`=0: stay.
- `CONV`: one iteration per edge.
  - First, every working nibble >= 5 gets +3 (4-bit add, no carry between nibbles).
  - Then shift {working, shift register} left by 1. The shift register MSB enters the working LSB.
  - The counter increments.
  - The edge that performs iteration WIDTH goes to `FINISH`.
- `FINISH`: at the next edge, the working register is copied to `BCD` (with blanking, see Configuration). `DONE` is set to 1 and the state goes to `IDLE`.
- `DONE` is registered. It is high for exactly the one cycle after the `FINISH` edge and cleared on the following edge.
- `BUSY` = (state != `IDLE`). It is decoded from the state register only, with no combinational path from `START`.
- `BCD` holds its previous value for the whole conversion. Intermediate values are never visible.
- `START` while `BUSY`=1 is ignored. It is not queued, and `BIN` is not resampled.
- `START` in the cycle where `DONE`=1 (state `IDLE`) is accepted normally. This gives back-to-back conversions.
- Counter width is ceil(log2(WIDTH+1)). No overflow is possible when the `DIGITS` constraint holds.

## Timing
- Reset (RESET_N=0 at an edge):
  - state → `IDLE`; `BUSY`=0; `DONE`=0.
  - `BCD` = all nibbles 4'hF (display blank).
  - Working/shift registers and counter cleared.
- Reset mid-conversion aborts the conversion. No `DONE` pulse is produced and `BCD` goes blank.
- Latency: `START` accepted at edge e0.
  - `BUSY`=1 from after e0 until after e(WIDTH+1).
  - Iterations happen at e1..eWIDTH.
  - `BCD` updates, `DONE`=1 and `BUSY`=0 after e(WIDTH+1).
  - With defaults, `DONE` occurs 17 cycles after the accepting edge.
- Throughput: one conversion per WIDTH+2 cycles when `START` is held high.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - At the `FINISH` copy, scan from digit DIGITS-1 downward. Each zero digit before the first nonzero digit is replaced by 4'hF.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Not defined:
  - All digits are copied unchanged and are always 0–9.
  - 4'hF appears only as the reset value.

## Test plan
- Reset:
  - Hold RESET_N=0 for 1 edge.
  - Required: `BUSY`=0, `DONE`=0, `BCD`=20'hFFFFF.
  - Then release, with `START`=0 for 20 cycles. Required: no change.
- BIN=16'd12345, START high for 1 cycle:
  - Required: `BUSY` high for 17 cycles.
  - Required: `DONE` high for exactly 1 cycle, 17 cycles after the accepting edge.
  - Required: `BCD`=20'h12345.
- BIN=16'hFFFF:
  - Required: `BCD`=20'h65535.
  - Then BIN=16'd0. Required: `BCD`=20'h00000 without the macro, 20'hFFFF0 with it.
- BIN=16'd42:
  - Required: `BCD`=20'h00042 without `LEADING_ZERO_BLANK_EN`, 20'hFFF42 with it.
- Ignored START:
  - Convert 16'd12345. Pulse START with BIN=16'd9 at cycle 5 of `BUSY`.
  - Required: single `DONE`, `BCD`=20'h12345, no second conversion.
  - Then assert START in the `DONE` cycle with BIN=16'd9. Required: accepted, `BCD`=20'h00009 17 cycles later.
- Reset mid-conversion:
  - Start 16'd500, assert RESET_N=0 at cycle 8 of `BUSY`.
  - Required: no `DONE`, `BCD`=20'hFFFFF, `BUSY`=0.
  - A following START with 16'd500. Required: `BCD`=20'h00500.
